// File: rtl/winograd_pe_acc_if.sv
// Port bundle for winograd_pe_acc.
//   slave  : the PE side (instantiated by winograd_pe_acc)
//   master : the surrounding array / memory side
// Result handshake: a tile transfers on any clock edge where
// result_valid_o && result_ready_i. While result_valid_o is high and
// result_ready_i is low, result_tile_o and result_address_o hold steady.
// dbg_acc_state exposes the accumulator FSM (0 = IDLE, 1 = ACC).
interface winograd_pe_acc_if #(
   parameter int DATA_W = 14,
   parameter int WGT_W  = 12,
   parameter int OUT_W  = 16,
   parameter int ADDR_W = 8
);
   logic [0:5][0:5][DATA_W-1:0] data_tile_i;
   logic                        data_valid_i;
   logic [ADDR_W-1:0]           data_addr_i;
   logic                        data_first_i;
   logic                        data_last_i;
   logic                        size_type_i;
   logic [ADDR_W-1:0]           block_cnt_i;
   logic [0:5][0:5][WGT_W-1:0]  weight_tile_i;
   logic                        weight_valid_i;
   logic [ADDR_W-1:0]           weight_od_i;

   logic [0:5][0:5][DATA_W-1:0] data_tile_reg_o;
   logic                        data_valid_o;
   logic [ADDR_W-1:0]           data_addr_o;
   logic                        data_first_o;
   logic                        data_last_o;
   logic                        size_type_o;
   logic [ADDR_W-1:0]           block_cnt_o;
   logic [0:5][0:5][WGT_W-1:0]  weight_tile_reg_o;
   logic                        weight_valid_o;
   logic [ADDR_W-1:0]           weight_od_o;

   logic [0:5][0:5][OUT_W-1:0]  result_tile_o;
   logic [ADDR_W-1:0]           result_address_o;
   logic                        result_valid_o;
   logic                        result_ready_i;
   logic                        overflow_o;
   logic                        dbg_acc_state;

   modport slave (
      input  data_tile_i, data_valid_i, data_addr_i, data_first_i, data_last_i,
             size_type_i, block_cnt_i, weight_tile_i, weight_valid_i, weight_od_i,
             result_ready_i,
      output data_tile_reg_o, data_valid_o, data_addr_o, data_first_o, data_last_o,
             size_type_o, block_cnt_o, weight_tile_reg_o, weight_valid_o, weight_od_o,
             result_tile_o, result_address_o, result_valid_o, overflow_o, dbg_acc_state
   );

   modport master (
      output data_tile_i, data_valid_i, data_addr_i, data_first_i, data_last_i,
             size_type_i, block_cnt_i, weight_tile_i, weight_valid_i, weight_od_i,
             result_ready_i,
      input  data_tile_reg_o, data_valid_o, data_addr_o, data_first_o, data_last_o,
             size_type_o, block_cnt_o, weight_tile_reg_o, weight_valid_o, weight_od_o,
             result_tile_o, result_address_o, result_valid_o, overflow_o, dbg_acc_state
   );
endinterface

// File: rtl/winograd_pe_acc.sv
// Winograd systolic PE: forwards data down / weights right, multiplies the
// registered tiles element-wise, accumulates across input-depth channels,
// applies the F(4x4,3x3) output transform (or 6x6 bypass) and offers the
// tile to memory through a valid/ready handshake.
// Optional macro WINO_PE_SAT_EN: saturating accumulator and output clamp;
// without it both wrap (two's-complement truncation).
module winograd_pe_acc #(
   parameter int DATA_W     = 14,
   parameter int WGT_W      = 12,
   parameter int PROD_SHIFT = 7,
   parameter int ACC_W      = 24,
   parameter int OUT_SHIFT  = 4,
   parameter int OUT_W      = 16,
   parameter int ADDR_W     = 8
) (
   input logic               clk,
   input logic               reset,
   winograd_pe_acc_if.slave  bus
);
   localparam int PW = DATA_W + WGT_W;

   typedef logic [0:5][0:5][ACC_W-1:0] acc_tile_t;
   typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} acc_state_t;

   // Row r of AT applied to a 6-vector; multiplies by 2/4/8 are shifts.
   function automatic logic [ACC_W-1:0] f_at(input logic [0:5][ACC_W-1:0] v, input logic [1:0] r);
      logic signed [ACC_W-1:0] a0, a1, a2, a3, a4, a5, y;
      a0 = $signed(v[0]); a1 = $signed(v[1]); a2 = $signed(v[2]);
      a3 = $signed(v[3]); a4 = $signed(v[4]); a5 = $signed(v[5]);
      case (r)
         2'd0:    y = a0 + a1 + a2 + a3 + a4;
         2'd1:    y = a1 - a2 + (a3 <<< 1) - (a4 <<< 1);
         2'd2:    y = a1 + a2 + (a3 <<< 2) + (a4 <<< 2);
         default: y = a1 - a2 + (a3 <<< 3) - (a4 <<< 3) + a5;
      endcase
      return y;
   endfunction

   // Full-precision product, scaled down and fitted to the accumulator width.
   function automatic logic [ACC_W-1:0] f_mul(input logic [DATA_W-1:0] d, input logic [WGT_W-1:0] w);
      logic signed [PW-1:0] p;
      p = PW'($signed(d)) * PW'($signed(w));
      p = p >>> PROD_SHIFT;
      return ACC_W'(p);
   endfunction

   // Accumulator add: one guard bit detects overflow.
   function automatic logic [ACC_W-1:0] f_acc_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
      logic [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
`ifdef WINO_PE_SAT_EN
      if (s[ACC_W] != s[ACC_W-1])
         return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
      return s[ACC_W-1:0];
   endfunction

`ifdef WINO_PE_SAT_EN
   localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;
`endif

   // Final scaling and narrowing to the result width.
   function automatic logic [OUT_W-1:0] f_out(input logic [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] sh;
      sh = $signed(v) >>> OUT_SHIFT;
`ifdef WINO_PE_SAT_EN
      if (sh > OUT_MAX) sh = OUT_MAX;
      if (sh < OUT_MIN) sh = OUT_MIN;
`endif
      return sh[OUT_W-1:0];
   endfunction

   // S1 registers (also the systolic pass-through outputs)
   logic [0:5][0:5][DATA_W-1:0] r_d_tile;
   logic [0:5][0:5][WGT_W-1:0]  r_w_tile;
   logic                        r_d_valid, r_d_first, r_d_last, r_w_valid;
   logic [ADDR_W-1:0]           r_d_addr, r_w_od;

   // S2 product stage
   acc_tile_t                   w_prod, r_p_tile;
   logic                        r_p_valid, r_p_first, r_p_last, r_p_mode;
   logic [ADDR_W-1:0]           w_p_addr, r_p_addr;

   // S3 accumulator FSM
   acc_state_t                  r_state, w_state_d;
   acc_tile_t                   r_acc, w_acc_d, w_base;
   logic                        r_mode, w_mode_d, w_load;
   logic [ADDR_W-1:0]           r_addr, w_addr_d;
   acc_tile_t                   r_m;
   logic                        r_m_valid, r_m_mode;
   logic [ADDR_W-1:0]           r_m_addr;

   // S4 first transform half
   acc_tile_t                   w_t, r_t;
   logic [0:5][ACC_W-1:0]       w_col;
   logic                        r_t_valid, r_t_mode;
   logic [ADDR_W-1:0]           r_t_addr;

   // S5 output
   logic [0:5][0:5][OUT_W-1:0]  w_fin, r_res;
   logic                        r_res_valid, r_ovf;
   logic [ADDR_W-1:0]           r_res_addr;

   assign bus.data_tile_reg_o   = r_d_tile;
   assign bus.data_valid_o      = r_d_valid;
   assign bus.data_addr_o       = r_d_addr;
   assign bus.data_first_o      = r_d_first;
   assign bus.data_last_o       = r_d_last;
   assign bus.size_type_o       = bus.size_type_i;
   assign bus.block_cnt_o       = bus.block_cnt_i;
   assign bus.weight_tile_reg_o = r_w_tile;
   assign bus.weight_valid_o    = r_w_valid;
   assign bus.weight_od_o       = r_w_od;
   assign bus.result_tile_o     = r_res;
   assign bus.result_address_o  = r_res_addr;
   assign bus.result_valid_o    = r_res_valid;
   assign bus.overflow_o        = r_ovf;
   assign bus.dbg_acc_state     = r_state;

   // S1: register each input group, zeroing it when its valid is low
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_d_tile <= '0; r_d_valid <= 1'b0; r_d_addr <= '0; r_d_first <= 1'b0; r_d_last <= 1'b0;
         r_w_tile <= '0; r_w_valid <= 1'b0; r_w_od <= '0;
      end else begin
         r_d_tile  <= bus.data_valid_i ? bus.data_tile_i : '0;
         r_d_valid <= bus.data_valid_i;
         r_d_addr  <= bus.data_valid_i ? bus.data_addr_i : '0;
         r_d_first <= bus.data_valid_i & bus.data_first_i;
         r_d_last  <= bus.data_valid_i & bus.data_last_i;
         r_w_tile  <= bus.weight_valid_i ? bus.weight_tile_i : '0;
         r_w_valid <= bus.weight_valid_i;
         r_w_od    <= bus.weight_valid_i ? bus.weight_od_i : '0;
      end
   end

   // S2: element-wise products and the output address of this beat
   always_comb begin
      w_prod = '0;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++)
            w_prod[i][j] = f_mul(r_d_tile[i][j], r_w_tile[i][j]);
      w_p_addr = ADDR_W'(r_w_od * bus.block_cnt_i + r_d_addr);
   end

   // S2: product register, only meaningful when both tiles were valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_p_tile <= '0; r_p_valid <= 1'b0; r_p_first <= 1'b0; r_p_last <= 1'b0;
         r_p_mode <= 1'b0; r_p_addr <= '0;
      end else begin
         r_p_valid <= r_d_valid & r_w_valid;
         r_p_tile  <= w_prod;
         r_p_first <= r_d_first;
         r_p_last  <= r_d_last;
         r_p_mode  <= bus.size_type_i;
         r_p_addr  <= w_p_addr;
      end
   end

   // S3: accumulator next state; a first beat restarts, IDLE ignores non-first beats
   always_comb begin
      w_state_d = r_state;
      w_acc_d   = r_acc;
      w_mode_d  = r_mode;
      w_addr_d  = r_addr;
      w_load    = 1'b0;
      w_base    = '0;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++)
            w_base[i][j] = r_p_first ? r_p_tile[i][j] : f_acc_add(r_acc[i][j], r_p_tile[i][j]);
      if (r_p_valid && (r_p_first || r_state == S_ACC)) begin
         if (r_p_first) begin
            w_mode_d = r_p_mode;
            w_addr_d = r_p_addr;
         end
         w_acc_d = w_base;
         if (r_p_last) begin
            w_load    = 1'b1;
            w_state_d = S_IDLE;
         end else begin
            w_state_d = S_ACC;
         end
      end
   end

   // S3: FSM state, running sum and hand-off of a completed sum to the transform
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE; r_acc <= '0; r_mode <= 1'b0; r_addr <= '0;
         r_m <= '0; r_m_valid <= 1'b0; r_m_mode <= 1'b0; r_m_addr <= '0;
      end else begin
         r_state   <= w_state_d;
         r_acc     <= w_acc_d;
         r_mode    <= w_mode_d;
         r_addr    <= w_addr_d;
         r_m_valid <= w_load;
         if (w_load) begin
            r_m      <= w_acc_d;
            r_m_mode <= w_mode_d;
            r_m_addr <= w_addr_d;
         end
      end
   end

   // S4: T = AT * M column by column (mode 1) or bypass (mode 0)
   always_comb begin
      w_t   = '0;
      w_col = '0;
      for (int k = 0; k < 6; k++) begin
         for (int r = 0; r < 6; r++)
            w_col[r] = r_m[r][k];
         for (int i = 0; i < 6; i++)
            if (r_m_mode)
               w_t[i][k] = (i < 4) ? f_at(w_col, 2'(i)) : '0;
            else
               w_t[i][k] = r_m[i][k];
      end
   end

   // S4: transform register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_t <= '0; r_t_valid <= 1'b0; r_t_mode <= 1'b0; r_t_addr <= '0;
      end else begin
         r_t_valid <= r_m_valid;
         if (r_m_valid) begin
            r_t      <= w_t;
            r_t_mode <= r_m_mode;
            r_t_addr <= r_m_addr;
         end
      end
   end

   // S5: R = T * A (4x4 in mode 1, zero border), then scale and narrow
   always_comb begin
      w_fin = '0;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++)
            if (r_t_mode)
               w_fin[i][j] = (i < 4 && j < 4) ? f_out(f_at(r_t[i], 2'(j))) : '0;
            else
               w_fin[i][j] = f_out(r_t[i][j]);
   end

   // S5: output holding register; a tile arriving while stalled is dropped and flagged
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_res <= '0; r_res_addr <= '0; r_res_valid <= 1'b0; r_ovf <= 1'b0;
      end else if (r_t_valid && r_res_valid && !bus.result_ready_i) begin
         r_ovf <= 1'b1;
      end else if (r_t_valid) begin
         r_res       <= w_fin;
         r_res_addr  <= r_t_addr;
         r_res_valid <= 1'b1;
      end else if (r_res_valid && bus.result_ready_i) begin
         r_res_valid <= 1'b0;
      end
   end
endmodule
